// File: rtl/n_seq_div.sv
// Sequential n-bit unsigned restoring divider with start/busy/done handshake.
// Optional macro DIV_ZERO_DETECT_EN: a zero divisor completes at once with dz set.
module n_seq_div #(
  parameter int n = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [n-1:0] q,
  output logic [n-1:0] r,
  output logic         dz
);

  localparam int CW = (n > 2) ? $clog2(n) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state_reg, state_next;
  logic [CW-1:0]  count_reg;
  logic [n:0]     rem_reg;
  logic [n-1:0]   quo_reg;
  logic [n-1:0]   div_reg;

  logic [n+1:0]   rem_shift;
  logic [n+1:0]   diff;
  logic           borrow;
  logic [n:0]     rem_next;
  logic [n-1:0]   quo_next;
  logic           last_iter;
  logic           zero_div;

`ifdef DIV_ZERO_DETECT_EN
  assign zero_div = (b == '0);
`else
  assign zero_div = 1'b0;
`endif

  // Trial subtraction R + ~D + 1, widened by one bit so the top bit is a clean borrow.
  assign rem_shift = {rem_reg, quo_reg[n-1]};
  assign diff      = rem_shift + {2'b11, ~div_reg} + (n+2)'(1);
  assign borrow    = diff[n+1];
  assign rem_next  = borrow ? rem_shift[n:0] : diff[n:0];
  assign quo_next  = {quo_reg[n-2:0], ~borrow};
  assign last_iter = (count_reg == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (start) state_next = zero_div ? DONE : RUN;
      RUN:  if (last_iter) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_reg == RUN);
    done = (state_reg == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
      rem_reg   <= '0;
      quo_reg   <= '0;
      div_reg   <= '0;
      q         <= '0;
      r         <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            quo_reg   <= a;
            div_reg   <= b;
            rem_reg   <= '0;
            count_reg <= CW'(n - 1);
            if (zero_div) begin
              q <= '1;
              r <= a;
            end
          end
        end
        RUN: begin
          rem_reg <= rem_next;
          quo_reg <= quo_next;
          if (last_iter) begin
            q <= quo_next;
            r <= rem_next[n-1:0];
          end else begin
            count_reg <= count_reg - CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef DIV_ZERO_DETECT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dz <= 1'b0;
    end else if (state_reg == IDLE && start) begin
      dz <= zero_div;
    end
  end
`else
  assign dz = 1'b0;
`endif

endmodule
